skylark_dmem_wbuf: RTL

- Data-memory responder for the core's writeback-stage memory interface. Receives store requests (MemWriteW, ALUResultW, WriteData) and returns ReadData.
- Stores enter a small in-order write buffer. The buffer drains into a word-addressed storage array at a fixed slow rate, which models a backing store with multi-cycle write latency.
- Reads forward from the youngest matching buffer entry, so the core always observes its own stores.
- Asserts a stall when a store cannot be accepted.

---
 rtl/skylark_dmem_wbuf.sv | 134 +++++++++++++
 1 files changed

// File: rtl/skylark_dmem_wbuf.sv
// Data memory with an in-order write buffer that retires one entry every WR_CYCLES cycles; reads forward from the youngest buffered store.
// Latency: ReadData combinational, stores retire in order. Backpressure: DStall holds a store while the buffer is full and nothing drains.
module skylark_dmem_wbuf #(
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 4,
    parameter int WR_CYCLES = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      MemWriteW,
    input  logic [31:0]               ALUResultW,
    input  logic [31:0]               WriteData,
    output logic [31:0]               ReadData,
    output logic                      DStall,
    output logic                      BufEmpty,
    output logic [$clog2(DEPTH):0]    BufCount
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DC_W  = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [DC_W-1:0]  LAST_CNT = DC_W'(WR_CYCLES - 1);

    typedef enum logic {
        IDLE,
        WAIT
    } drainState_t;

    drainState_t state, stateNext;

    logic [PTR_W-1:0]  head, headNext;
    logic [PTR_W-1:0]  tail, tailNext;
    logic [PTR_W-1:0]  fwdPtr;
    logic [CNT_W-1:0]  count, countNext;
    logic [DC_W-1:0]   drainCnt, drainCntNext;
    logic              drainNow;
    logic              accept;

    logic [ADDR_W-1:0] bufIdx [DEPTH];
    logic [31:0]       bufDat [DEPTH];
    logic [31:0]       mem    [2**ADDR_W];

    logic [ADDR_W-1:0] wordIdx;
    logic              unusedAddrBits;

    assign wordIdx        = ALUResultW[ADDR_W+1:2];
    assign unusedAddrBits = ^{ALUResultW[31:ADDR_W+2], ALUResultW[1:0]};

    always_comb begin
        stateNext    = state;
        drainCntNext = drainCnt;
        drainNow     = 1'b0;
        DStall       = 1'b0;
        accept       = 1'b0;
        headNext     = head;
        tailNext     = tail;
        countNext    = count;

        if (state == WAIT) begin
            if (drainCnt == LAST_CNT) begin
                drainNow     = 1'b1;
                drainCntNext = '0;
            end else begin
                drainCntNext = drainCnt + 1'b1;
            end
        end else begin
            drainCntNext = '0;
        end

        // A drain on this edge frees the slot, so a full buffer can still take the store.
        DStall = MemWriteW && (count == FULL_CNT) && !drainNow;
        accept = MemWriteW && !DStall;

        if (accept) begin
            tailNext = tail + 1'b1;
        end
        if (drainNow) begin
            headNext = head + 1'b1;
        end

        countNext = count + CNT_W'(accept) - CNT_W'(drainNow);
        stateNext = (countNext != '0) ? WAIT : IDLE;
        if (stateNext == IDLE) begin
            drainCntNext = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            drainCnt <= '0;
            BufEmpty <= 1'b1;
        end else begin
            state    <= stateNext;
            head     <= headNext;
            tail     <= tailNext;
            count    <= countNext;
            drainCnt <= drainCntNext;
            BufEmpty <= (countNext == '0);
        end
    end

    assign BufCount = count;

    always_ff @(posedge clk) begin
        if (accept) begin
            bufIdx[tail] <= wordIdx;
            bufDat[tail] <= WriteData;
        end
    end

    // drainNow is forced low while reset holds state in IDLE, so an abandoned entry never lands.
    always_ff @(posedge clk) begin
        if (drainNow) begin
            mem[bufIdx[head]] <= bufDat[head];
        end
    end

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        ReadData = mem[wordIdx];
        fwdPtr   = head;
        for (int i = 0; i < DEPTH; i++) begin
            fwdPtr = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (bufIdx[fwdPtr] == wordIdx)) begin
                ReadData = bufDat[fwdPtr];
            end
        end
    end

endmodule
